// File: rtl/counter_updown_mod.sv
// ============================================================================
// Module      : counter_updown_mod
// Description : General-purpose up/down event/timebase counter with enable,
//               prescaler, synchronous parallel load, programmable modulo
//               limit, wrap or saturate behaviour and wrap/overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_updown_mod #(
  parameter int SIZE     = 4,
  parameter int MAX_VAL  = (2**SIZE) - 1,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            up,
  input  logic            sat_mode,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            clr_ovf,
  output logic [SIZE-1:0] count,
  output logic            wrap,
  output logic            ovf,
  output logic            at_max,
  output logic            at_min
);

  // Prescaler counter is at least one bit wide so PRESCALE=1 still elaborates.
  localparam int              C_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [SIZE-1:0] C_MAX     = SIZE'(MAX_VAL);
  localparam logic [C_PS_W-1:0] C_PS_LAST = C_PS_W'(PRESCALE - 1);

  logic [SIZE-1:0]   count_q, count_d;
  logic [C_PS_W-1:0] ps_q, ps_d;
  logic              wrap_q, wrap_d;
  logic              ovf_q, ovf_d;
  logic              w_step;
  logic              w_hit;

  assign at_max = (count_q == C_MAX);
  assign at_min = (count_q == '0);
  assign w_step = en && (ps_q == C_PS_LAST);

  // Next-state: load beats step beats hold; limits are compared before the
  // add/subtract so the arithmetic never leaves the SIZE-bit range.
  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    wrap_d  = 1'b0;
    w_hit   = 1'b0;
    if (load) begin
      count_d = (load_val > C_MAX) ? C_MAX : load_val;
      ps_d    = '0;
    end else if (en) begin
      ps_d = w_step ? '0 : ps_q + C_PS_W'(1);
      if (w_step) begin
        if (up) begin
          if (at_max) begin
            w_hit = 1'b1;
            if (!sat_mode) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q + SIZE'(1);
          end
        end else begin
          if (at_min) begin
            w_hit = 1'b1;
            if (!sat_mode) begin
              count_d = C_MAX;
              wrap_d  = 1'b1;
            end
          end else begin
            count_d = count_q - SIZE'(1);
          end
        end
      end
    end
    // A limit hit in the same cycle as a clear keeps the flag set.
    ovf_d = w_hit ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ps_q    <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// ============================================================================
// Module      : tb_counter_updown_mod
// Description : Self-checking bench for counter_updown_mod. Four instances
//               cover the default configuration, MAX_VAL=9, PRESCALE=3 and
//               the degenerate MAX_VAL=0 case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_updown_mod;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [3:0] lv;
    logic       clr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] c;
    logic       w;
    logic       o;
  } vec_t;

  typedef struct {
    int         d;
    logic [3:0] c;
    logic       w;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  in_t        vin [4];
  logic [3:0] cnt [4];
  logic       wr  [4];
  logic       ov  [4];
  logic       amx [4];
  logic       amn [4];

  int checks = 0;
  int errors = 0;

  exp_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl[$];

  always #5 clk = ~clk;

  // Instance 0: defaults, 1: MAX_VAL=9, 2: PRESCALE=3, 3: MAX_VAL=0
  for (genvar g = 0; g < 4; g++) begin : g_dut
    counter_updown_mod #(
      .SIZE    (4),
      .MAX_VAL ((g == 1) ? 9 : ((g == 3) ? 0 : 15)),
      .PRESCALE((g == 2) ? 3 : 1)
    ) u_dut (
      .clk     (clk),
      .rst     (vin[g].rst),
      .en      (vin[g].en),
      .up      (vin[g].up),
      .sat_mode(vin[g].sat),
      .load    (vin[g].load),
      .load_val(vin[g].lv),
      .clr_ovf (vin[g].clr),
      .count   (cnt[g]),
      .wrap    (wr[g]),
      .ovf     (ov[g]),
      .at_max  (amx[g]),
      .at_min  (amn[g])
    );
  end

  function automatic logic [3:0] maxv(input int d);
    case (d)
      1:       return 4'd9;
      3:       return 4'd0;
      default: return 4'd15;
    endcase
  endfunction

  function automatic in_t mk(input logic rst, input logic en, input logic up,
                             input logic sat, input logic load, input int lv,
                             input logic clr);
    in_t r;
    r.rst  = rst;
    r.en   = en;
    r.up   = up;
    r.sat  = sat;
    r.load = load;
    r.lv   = 4'(lv);
    r.clr  = clr;
    return r;
  endfunction

  function automatic vec_t vv(input in_t i, input int c, input logic w, input logic o);
    vec_t r;
    r.in = i;
    r.c  = 4'(c);
    r.w  = w;
    r.o  = o;
    return r;
  endfunction

  // Drive one cycle on instance d (others idle), queue its expectation, then
  // pop it and compare once the edge has produced the registered result.
  task automatic cyc(input int d, input in_t v, input int c, input logic w,
                     input logic o, input string nm);
    exp_t       e;
    exp_t       g;
    string      n;
    logic [7:0] act;
    logic [7:0] req;
    for (int k = 0; k < 4; k++) vin[k] = (k == d) ? v : in_t'(0);
    e.d = d;
    e.c = 4'(c);
    e.w = w;
    e.o = o;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    g   = sb_q.pop_front();
    n   = nm_q.pop_front();
    act = {cnt[g.d], wr[g.d], ov[g.d], amx[g.d], amn[g.d]};
    req = {g.c, g.w, g.o, (g.c == maxv(g.d)), (g.c == 4'd0)};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got count=%0d wrap=%b ovf=%b at_max=%b at_min=%b, expected count=%0d wrap=%b ovf=%b at_max=%b at_min=%b",
               n, act[7:4], act[3], act[2], act[1], act[0],
               req[7:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) vin[k] = mk(1, 0, 0, 0, 0, 0, 0);

    // Reset state on every instance
    for (int i = 0; i < 4; i++) cyc(0, mk(1, 0, 0, 0, 0, 0, 0), 0, 0, 0, "A reset");
    for (int d = 1; d < 4; d++) cyc(d, mk(1, 0, 0, 0, 0, 0, 0), 0, 0, 0, "reset");

    // Free-running up count through the wrap
    for (int i = 1; i <= 17; i++)
      cyc(0, mk(0, 1, 1, 0, 0, 0, 0), i % 16, (i == 16), (i >= 16), "A up count");

    // Saturate, clear, priority and down-wrap vectors on the default instance
    tbl.push_back(vv(mk(0, 0, 0, 0, 0, 0, 1), 1, 0, 0));   // clr_ovf
    tbl.push_back(vv(mk(0, 0, 0, 1, 1, 13, 0), 13, 0, 0)); // load 13
    tbl.push_back(vv(mk(0, 1, 1, 1, 0, 0, 0), 14, 0, 0));
    tbl.push_back(vv(mk(0, 1, 1, 1, 0, 0, 0), 15, 0, 0));
    tbl.push_back(vv(mk(0, 1, 1, 1, 0, 0, 0), 15, 0, 1));  // saturate hit
    tbl.push_back(vv(mk(0, 1, 1, 1, 0, 0, 0), 15, 0, 1));
    tbl.push_back(vv(mk(0, 1, 1, 1, 0, 0, 0), 15, 0, 1));
    tbl.push_back(vv(mk(0, 0, 0, 1, 0, 0, 1), 15, 0, 0));  // clear, en=0
    tbl.push_back(vv(mk(0, 1, 1, 1, 0, 0, 1), 15, 0, 1));  // set beats clear
    tbl.push_back(vv(mk(0, 1, 1, 1, 1, 7, 0), 7, 0, 1));   // load beats en
    tbl.push_back(vv(mk(1, 1, 1, 0, 1, 7, 0), 0, 0, 0));   // rst beats all
    tbl.push_back(vv(mk(0, 0, 0, 0, 1, 15, 0), 15, 0, 0));
    tbl.push_back(vv(mk(0, 1, 1, 0, 0, 0, 1), 0, 1, 1));   // wrap + clr
    tbl.push_back(vv(mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 1));   // pulse ends
    tbl.push_back(vv(mk(0, 0, 0, 0, 0, 0, 1), 0, 0, 0));
    tbl.push_back(vv(mk(0, 1, 0, 1, 0, 0, 0), 0, 0, 1));   // saturate at 0
    tbl.push_back(vv(mk(0, 1, 0, 0, 0, 0, 0), 15, 1, 1));  // down wrap
    tbl.push_back(vv(mk(0, 1, 0, 0, 0, 0, 0), 14, 0, 1));
    foreach (tbl[i]) cyc(0, tbl[i].in, int'(tbl[i].c), tbl[i].w, tbl[i].o, "A table");

    // MAX_VAL=9: down wrap and load clamp
    cyc(1, mk(0, 0, 0, 0, 1, 1, 0), 1, 0, 0, "B load 1");
    cyc(1, mk(0, 1, 0, 0, 0, 0, 0), 0, 0, 0, "B down to 0");
    cyc(1, mk(0, 1, 0, 0, 0, 0, 0), 9, 1, 1, "B down wrap");
    cyc(1, mk(0, 1, 0, 0, 0, 0, 0), 8, 0, 1, "B down 8");
    cyc(1, mk(0, 0, 0, 0, 1, 12, 0), 9, 0, 1, "B load clamp");
    cyc(1, mk(0, 1, 1, 0, 0, 0, 0), 0, 1, 1, "B up wrap");

    // PRESCALE=3: phase, enable gaps, load restart, reset mid-prescale
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 0, 0, 0, "C ps1");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 0, 0, 0, "C ps2");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 1, 0, 0, "C step1");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 1, 0, 0, "C ps1b");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 1, 0, 0, "C ps2b");
    cyc(2, mk(0, 0, 1, 0, 0, 0, 0), 1, 0, 0, "C en0 a");
    cyc(2, mk(0, 0, 1, 0, 0, 0, 0), 1, 0, 0, "C en0 b");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 2, 0, 0, "C stretched step");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 2, 0, 0, "C ps1c");
    cyc(2, mk(0, 1, 1, 0, 1, 5, 0), 5, 0, 0, "C load mid");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 5, 0, 0, "C restart1");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 5, 0, 0, "C restart2");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 6, 0, 0, "C step after load");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 6, 0, 0, "C ps1d");
    cyc(2, mk(1, 1, 1, 0, 0, 0, 0), 0, 0, 0, "C rst mid");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 0, 0, 0, "C post rst 1");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 0, 0, 0, "C post rst 2");
    cyc(2, mk(0, 1, 1, 0, 0, 0, 0), 1, 0, 0, "C post rst step");

    // MAX_VAL=0: every step hits the limit
    cyc(3, mk(0, 1, 1, 0, 0, 0, 0), 0, 1, 1, "D up wrap");
    cyc(3, mk(0, 1, 0, 0, 0, 0, 0), 0, 1, 1, "D down wrap");
    cyc(3, mk(0, 1, 1, 1, 0, 0, 0), 0, 0, 1, "D saturate");
    cyc(3, mk(0, 0, 0, 0, 1, 5, 0), 0, 0, 1, "D load clamp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
